// File: rtl/imem_loader.sv
// Instruction memory program loader: assembles big-endian 16-bit words from a
// byte stream, writes them to consecutive even addresses and verifies an XOR checksum.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [7:0]        word_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    localparam logic [8:0] MAX_WORDS_C = MAX_WORDS[8:0];

    state_t            state_r;
    state_t            state_next_s;
    logic [7:0]        len_r;
    logic [7:0]        chk_r;
    logic [ADDR_W-1:0] addr_r;
    logic              accept_s;
    logic              byte_ready_next_s;
    logic              im_we_next_s;
    logic              cpu_hold_next_s;
    logic              done_next_s;
    logic              error_next_s;

    // Running checksum step: fold one stream byte into the XOR accumulator.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        chk_fold = acc ^ b;
    endfunction

    assign accept_s = byte_valid & byte_ready;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is honoured only in the idle/terminal states.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_next_s = ST_LEN;
                else       state_next_s = state_r;
            end
            ST_LEN: begin
                if (accept_s) begin
                    if ((byte_data == 8'd0) || ({1'b0, byte_data} > MAX_WORDS_C)) state_next_s = ST_ERR;
                    else                                                          state_next_s = ST_HI;
                end else begin
                    state_next_s = ST_LEN;
                end
            end
            ST_HI: begin
                if (accept_s) state_next_s = ST_LO;
                else          state_next_s = ST_HI;
            end
            ST_LO: begin
                if (accept_s) state_next_s = ST_WRITE;
                else          state_next_s = ST_LO;
            end
            ST_WRITE: begin
                if ((word_count + 8'd1) == len_r) state_next_s = ST_CHK;
                else                              state_next_s = ST_HI;
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (byte_data == chk_r) state_next_s = ST_DONE;
                    else                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_CHK;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode from the next state so the strobes are registered yet state-aligned.
    always_comb begin
        byte_ready_next_s = 1'b0;
        im_we_next_s      = 1'b0;
        cpu_hold_next_s   = 1'b1;
        done_next_s       = 1'b0;
        error_next_s      = 1'b0;
        case (state_next_s)
            ST_LEN, ST_HI, ST_LO, ST_CHK: byte_ready_next_s = 1'b1;
            ST_WRITE:                     im_we_next_s      = 1'b1;
            ST_DONE: begin
                done_next_s     = 1'b1;
                cpu_hold_next_s = 1'b0;
            end
            ST_ERR:                       error_next_s      = 1'b1;
            default:                      byte_ready_next_s = 1'b0;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_ready <= 1'b0;
            im_we      <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            byte_ready <= byte_ready_next_s;
            im_we      <= im_we_next_s;
            cpu_hold   <= cpu_hold_next_s;
            done       <= done_next_s;
            error      <= error_next_s;
        end
    end

    // Datapath: length, checksum, word assembly and address/count stepping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_r      <= 8'd0;
            chk_r      <= 8'd0;
            addr_r     <= '0;
            word_count <= 8'd0;
            im_addr    <= '0;
            im_wdata   <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        word_count <= 8'd0;
                        addr_r     <= '0;
                        chk_r      <= 8'd0;
                    end
                end
                ST_LEN: begin
                    if (accept_s) len_r <= byte_data;
                end
                ST_HI: begin
                    if (accept_s) begin
                        im_wdata[DATA_W-1:8] <= byte_data;
                        chk_r                <= chk_fold(chk_r, byte_data);
                    end
                end
                ST_LO: begin
                    // The address is presented together with the strobe in the write cycle.
                    if (accept_s) begin
                        im_wdata[7:0] <= byte_data;
                        chk_r         <= chk_fold(chk_r, byte_data);
                        im_addr       <= addr_r;
                    end
                end
                ST_WRITE: begin
                    word_count <= word_count + 8'd1;
                    addr_r     <= addr_r + ADDR_W'(2'd2);
                end
                default: begin
                    len_r <= len_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete loads plus hand sequences
// for async reset, error recovery, mid-load reset and the maximum-length load.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [7:0]  im_addr;
    logic [15:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [7:0]  word_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    typedef struct {
        logic [0:7][7:0]  b;
        int               n;
        int               gap;
        bit               start_hi;
        int               nw;
        logic [0:1][15:0] d;
        logic             dn;
        logic             er;
        logic [7:0]       wc;
    } vec_t;

    vec_t tbl [0:4];

    imem_loader #(.ADDR_W(8), .DATA_W(16), .MAX_WORDS(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe away from the active edge.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int cnt;
        cnt = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) check("byte_accept_timeout", 32'(cnt), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'hEE;
    endtask

    task automatic run_stream(input logic [7:0] s[$], input int gap, input bit start_hi);
        for (int i = 0; i < s.size(); i++) begin
            for (int g = 0; g < gap; g++) begin
                start = (start_hi && i == 1 && g == 0);
                @(negedge clk);
            end
            start = 1'b0;
            send_byte(s[i]);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] chk;

        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

        tbl[0] = '{b: {8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40,8'h00,8'h00}, n: 6, gap: 0, start_hi: 1'b0,
                   nw: 2, d: {16'h1234,16'hABCD}, dn: 1'b1, er: 1'b0, wc: 8'd2};
        tbl[1] = '{b: {8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h41,8'h00,8'h00}, n: 6, gap: 0, start_hi: 1'b0,
                   nw: 2, d: {16'h1234,16'hABCD}, dn: 1'b0, er: 1'b1, wc: 8'd2};
        tbl[2] = '{b: {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n: 1, gap: 0, start_hi: 1'b0,
                   nw: 0, d: {16'h0000,16'h0000}, dn: 1'b0, er: 1'b1, wc: 8'd0};
        tbl[3] = '{b: {8'h81,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, n: 1, gap: 0, start_hi: 1'b0,
                   nw: 0, d: {16'h0000,16'h0000}, dn: 1'b0, er: 1'b1, wc: 8'd0};
        tbl[4] = '{b: {8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h40,8'h00,8'h00}, n: 6, gap: 3, start_hi: 1'b1,
                   nw: 2, d: {16'h1234,16'hABCD}, dn: 1'b1, er: 1'b0, wc: 8'd2};

        // Asynchronous reset takes effect with no clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_im_we",      32'(im_we),      32'd0);
        check("rst_im_addr",    32'(im_addr),    32'd0);
        check("rst_im_wdata",   32'(im_wdata),   32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        check("rst_done",       32'(done),       32'd0);
        check("rst_error",      32'(error),      32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_byte_ready", 32'(byte_ready), 32'd0);

        for (int k = 0; k < 5; k++) begin
            wr_addr_q.delete();
            wr_data_q.delete();
            q.delete();
            for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].b[i]);
            do_start();
            check($sformatf("v%0d_len_ready", k), 32'(byte_ready), 32'd1);
            run_stream(q, tbl[k].gap, tbl[k].start_hi);
            check($sformatf("v%0d_nwrites", k), 32'(wr_addr_q.size()), 32'(tbl[k].nw));
            for (int j = 0; j < tbl[k].nw && j < wr_addr_q.size(); j++) begin
                check($sformatf("v%0d_addr%0d", k, j), 32'(wr_addr_q[j]), 32'(2 * j));
                check($sformatf("v%0d_data%0d", k, j), 32'(wr_data_q[j]), 32'(tbl[k].d[j]));
            end
            check($sformatf("v%0d_done", k),       32'(done),       32'(tbl[k].dn));
            check($sformatf("v%0d_error", k),      32'(error),      32'(tbl[k].er));
            check($sformatf("v%0d_cpu_hold", k),   32'(cpu_hold),   32'(!tbl[k].dn));
            check($sformatf("v%0d_word_count", k), 32'(word_count), 32'(tbl[k].wc));
            check($sformatf("v%0d_ready_end", k),  32'(byte_ready), 32'd0);
            repeat (2) @(negedge clk);
        end

        // From ERR, a new start clears error and enters LEN.
        do_start();
        check("err_restart_error", 32'(error),      32'd0);
        check("err_restart_ready", 32'(byte_ready), 32'd1);
        check("err_restart_hold",  32'(cpu_hold),   32'd1);
        check("err_restart_wc",    32'(word_count), 32'd0);

        // Reset after the first write of a two-word load.
        wr_addr_q.delete();
        wr_data_q.delete();
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        check("midload_we", 32'(im_we), 32'd1);
        @(negedge clk);
        check("midload_wc_before", 32'(word_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midload_rst_wc",    32'(word_count), 32'd0);
        check("midload_rst_hold",  32'(cpu_hold),   32'd1);
        check("midload_rst_ready", 32'(byte_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        wr_addr_q.delete();
        wr_data_q.delete();
        do_start();
        q = '{8'h01, 8'h00, 8'h07, 8'h07};
        run_stream(q, 0, 1'b0);
        check("one_nwrites", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check("one_addr", 32'(wr_addr_q[0]), 32'h00);
            check("one_data", 32'(wr_data_q[0]), 32'h0007);
        end
        check("one_done", 32'(done),     32'd1);
        check("one_hold", 32'(cpu_hold), 32'd0);

        // Maximum-length load ends exactly at byte address 0xFE.
        wr_addr_q.delete();
        wr_data_q.delete();
        q.delete();
        chk = 8'h00;
        q.push_back(8'h80);
        for (int i = 0; i < 128; i++) begin
            q.push_back(8'(i));
            q.push_back(8'(i + 3));
            chk = chk ^ 8'(i) ^ 8'(i + 3);
        end
        q.push_back(chk);
        do_start();
        run_stream(q, 0, 1'b0);
        check("max_nwrites", 32'(wr_addr_q.size()), 32'd128);
        if (wr_addr_q.size() == 128) begin
            check("max_first_addr", 32'(wr_addr_q[0]),   32'h00);
            check("max_last_addr",  32'(wr_addr_q[127]), 32'hFE);
            check("max_last_data",  32'(wr_data_q[127]), 32'h7F82);
        end
        check("max_done", 32'(done),       32'd1);
        check("max_wc",   32'(word_count), 32'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
